// File: rtl/register_window_bank.sv
// rtl/register_window_bank.sv - DEPTH x WIDTH register bank with random-write port and block/sliding stream loader
`timescale 1ns/1ps
module register_window_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   mode,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic                   out_ack,
    output logic                   out_valid,
    output logic [AW:0]            count,
    output logic [WIDTH*DEPTH-1:0] out
);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    localparam logic [AW:0]   LAST_CNT = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             accept;

    assign in_ready  = !clr && !wr_en && (state_q == FILL || mode);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == FULL);
    assign count     = count_q;

    // data[0] lands in the most significant slice of the flat bus
    always_comb begin
        out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            out[WIDTH*(DEPTH-i)-1 -: WIDTH] = data_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (clr) begin
            state_d = FILL;
            ptr_d   = '0;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) data_d[i] = '0;
        end else if (wr_en) begin
            // addresses past the last entry only exist for non-power-of-2 DEPTH
            if (int'(wr_addr) < DEPTH) data_d[wr_addr] = wr_data;
        end else if (state_q == FILL) begin
            if (accept) begin
                data_d[ptr_q] = in_data;
                if (count_q == LAST_CNT) begin
                    state_d = FULL;
                    ptr_d   = '0;
                    count_d = FULL_CNT;
                end else begin
                    ptr_d   = ptr_q + PTR_ONE;
                    count_d = count_q + 1'b1;
                end
            end
        end else if (out_ack) begin
            state_d = FILL;
            if (accept) begin
                // the colliding word starts the next window
                data_d[0] = in_data;
                ptr_d     = PTR_ONE;
                count_d   = (AW+1)'(1);
            end else begin
                ptr_d   = '0;
                count_d = '0;
            end
        end else if (accept) begin
            for (int i = 0; i < DEPTH - 1; i++) data_d[i] = data_q[i+1];
            data_d[DEPTH-1] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_register_window_bank.sv
// tb/tb_register_window_bank.sv - directed self-checking bench for register_window_bank (WIDTH=8, DEPTH=4)
`timescale 1ns/1ps
module tb_register_window_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        mode = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        out_ack = 1'b0;
    logic        out_valid;
    logic [2:0]  count;
    logic [31:0] out;

    int n_cmp = 0;
    int n_err = 0;

    register_window_bank #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_ack(out_ack), .out_valid(out_valid), .count(count), .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        step();
        check("rst_out", out, 32'h0);
        check("rst_count", count, 3'd0);
        check("rst_valid", out_valid, 1'b0);
        rst = 1'b1;
        #1;
        check("idle_ready", in_ready, 1'b1);
        step();

        // block mode fill
        mode = 1'b0;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        check("blk_partial_valid", out_valid, 1'b0);
        check("blk_partial_count", count, 3'd3);
        push(8'hA4);
        check("blk_full_valid", out_valid, 1'b1);
        check("blk_full_out", out, 32'hA1A2A3A4);
        check("blk_full_count", count, 3'd4);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        #1;
        check("blk_full_ready", in_ready, 1'b0);
        step();
        check("blk_hold_out", out, 32'hA1A2A3A4);
        in_valid = 1'b0;
        out_ack  = 1'b1;
        step();
        out_ack = 1'b0;
        #1;
        check("blk_ack_valid", out_valid, 1'b0);
        check("blk_ack_count", count, 3'd0);
        check("blk_ack_ready", in_ready, 1'b1);
        check("blk_ack_out", out, 32'hA1A2A3A4);

        // sliding window
        mode = 1'b1;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("sld_3_out", out, 32'h010203A4);
        check("sld_3_valid", out_valid, 1'b0);
        push(8'h04);
        check("sld_4_out", out, 32'h01020304);
        check("sld_4_valid", out_valid, 1'b1);
        push(8'h05);
        check("sld_5_out", out, 32'h02030405);
        push(8'h06);
        check("sld_6_out", out, 32'h03040506);
        check("sld_6_count", count, 3'd4);
        check("sld_6_valid", out_valid, 1'b1);

        // ack + accept collision
        out_ack = 1'b1;
        push(8'h77);
        out_ack = 1'b0;
        check("col_out", out, 32'h77040506);
        check("col_count", count, 3'd1);
        check("col_valid", out_valid, 1'b0);

        // random write precedence
        push(8'h55);
        check("rw_pre_count", count, 3'd2);
        wr_en    = 1'b1;
        wr_addr  = 2'd3;
        wr_data  = 8'hEE;
        in_valid = 1'b1;
        in_data  = 8'h99;
        #1;
        check("rw_ready", in_ready, 1'b0);
        step();
        wr_en    = 1'b0;
        in_valid = 1'b0;
        check("rw_out", out, 32'h775505EE);
        check("rw_count", count, 3'd2);
        push(8'h66);
        check("rw_next_out", out, 32'h775566EE);
        check("rw_next_count", count, 3'd3);

        // synchronous clear beats write and stream
        clr      = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 2'd0;
        wr_data  = 8'h11;
        in_valid = 1'b1;
        in_data  = 8'h22;
        #1;
        check("clr_ready", in_ready, 1'b0);
        step();
        clr      = 1'b0;
        wr_en    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("clr_out", out, 32'h0);
        check("clr_count", count, 3'd0);
        check("clr_valid", out_valid, 1'b0);
        check("clr_ready_after", in_ready, 1'b1);

        // mode switch while full, then async reset between edges
        mode = 1'b0;
        push(8'h10);
        push(8'h20);
        push(8'h30);
        push(8'h40);
        check("ms_full_out", out, 32'h10203040);
        check("ms_ready_blk", in_ready, 1'b0);
        mode = 1'b1;
        #1;
        check("ms_ready_sld", in_ready, 1'b1);
        mode = 1'b0;
        #1;
        check("ms_ready_back", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_out", out, 32'h0);
        check("arst_count", count, 3'd0);
        rst = 1'b1;
        step();
        check("arst_ready", in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
